// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - state encoding and sizing helper shared by serial_collector files
package serial_pkg;

  typedef enum logic [0:0] {
    ST_SHIFT  = 1'b0,
    ST_PARITY = 1'b1
  } state_t;

  // Counter must hold WIDTH+1 (parity bit) in the largest build.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/serial_collector_if.sv
// rtl/serial_collector_if.sv - serial bit input and word valid/ready output bundle
interface serial_collector_if #(
  parameter int WIDTH = 8
);

  logic             in_bit;
  logic             in_valid;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_bit,
    output in_valid,
    output out_ready,
    input  out_word,
    input  out_valid
  );

  modport slave (
    input  in_bit,
    input  in_valid,
    input  out_ready,
    output out_word,
    output out_valid
  );

endinterface

// File: rtl/out_holding_reg.sv
// rtl/out_holding_reg.sv - word holding register with publish/accept and sticky overrun
module out_holding_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             publish,
  input  logic [WIDTH-1:0] pub_word,
  input  logic             pub_perr,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  output logic             overrun,
  output logic             parity_err
);

  logic slot_free;

  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_word   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      // A publish into a slot being drained this cycle replaces it with no bubble.
      if (publish && slot_free) begin
        out_word   <= pub_word;
        out_valid  <= 1'b1;
        parity_err <= pub_perr;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (clear) begin
        overrun <= 1'b0;
      end else if (publish && !slot_free) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_collector.sv
// rtl/serial_collector.sv - serial-in word collector; SERIAL_COLLECTOR_PARITY_EN adds an even-parity bit per word
module serial_collector
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  serial_collector_if.slave             bus,
  output logic [cnt_width(WIDTH)-1:0]   bit_count,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int            CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PEAK_CNT  = CW'(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [WIDTH-1:0] pub_word;
  logic [CW-1:0]    base_count;
  logic             publish;
  logic             pub_perr;

  always_comb begin
    if (MSB_FIRST) sreg_shifted = {sreg[WIDTH-2:0], bus.in_bit};
    else           sreg_shifted = {bus.in_bit, sreg[WIDTH-1:1]};
  end

  // The post-parity count of WIDTH+1 is shown for one cycle only; a bit arriving then starts a new word.
  assign base_count = (bit_count == PEAK_CNT) ? '0 : bit_count;

  always_comb begin
    publish  = 1'b0;
    pub_word = sreg_shifted;
    pub_perr = 1'b0;
    if (!clear && bus.in_valid) begin
`ifdef SERIAL_COLLECTOR_PARITY_EN
      if (state == ST_PARITY) begin
        publish  = 1'b1;
        pub_word = sreg;
        pub_perr = (^sreg) ^ bus.in_bit;
      end
`else
      if (base_count == LAST_IDX) publish = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg      <= '0;
      bit_count <= '0;
      state     <= ST_SHIFT;
    end else if (clear) begin
      sreg      <= '0;
      bit_count <= '0;
      state     <= ST_SHIFT;
    end else if (bus.in_valid) begin
      if (state == ST_PARITY) begin
        bit_count <= PEAK_CNT;
        state     <= ST_SHIFT;
      end else begin
        sreg <= sreg_shifted;
        if (base_count == LAST_IDX) begin
`ifdef SERIAL_COLLECTOR_PARITY_EN
          bit_count <= CW'(WIDTH);
          state     <= ST_PARITY;
`else
          bit_count <= '0;
`endif
        end else begin
          bit_count <= base_count + 1'b1;
        end
      end
    end else if (bit_count == PEAK_CNT) begin
      bit_count <= '0;
    end
  end

  out_holding_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .publish    (publish),
    .pub_word   (pub_word),
    .pub_perr   (pub_perr),
    .out_ready  (bus.out_ready),
    .out_word   (bus.out_word),
    .out_valid  (bus.out_valid),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

endmodule

// File: tb/tb_serial_collector.sv
// tb/tb_serial_collector.sv - randomized, model-checked bench driving MSB-first and LSB-first collectors in lockstep
module tb_serial_collector;

  logic clock;
  logic reset;
  logic clear;
  logic in_bit;
  logic in_valid;
  logic out_ready;

  logic [3:0] cnt_m, cnt_l;
  logic       ovr_m, ovr_l, perr_m, perr_l;

  serial_collector_if #(.WIDTH(8)) if_m ();
  serial_collector_if #(.WIDTH(8)) if_l ();

  assign if_m.in_bit    = in_bit;
  assign if_m.in_valid  = in_valid;
  assign if_m.out_ready = out_ready;
  assign if_l.in_bit    = in_bit;
  assign if_l.in_valid  = in_valid;
  assign if_l.out_ready = out_ready;

  serial_collector #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clock(clock), .reset(reset), .clear(clear), .bus(if_m.slave),
    .bit_count(cnt_m), .overrun(ovr_m), .parity_err(perr_m)
  );

  serial_collector #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clock(clock), .reset(reset), .clear(clear), .bus(if_l.slave),
    .bit_count(cnt_l), .overrun(ovr_l), .parity_err(perr_l)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: bits of the current word kept as a list, words formed by bit placement.
  bit         q[$];
  logic [7:0] pend_m, pend_l;
  logic [7:0] m_word_m, m_word_l;
  logic       m_valid, m_overrun, m_perr, m_par_phase;
  int         m_count;

  task automatic model_reset();
    q.delete();
    pend_m = 8'h00; pend_l = 8'h00;
    m_word_m = 8'h00; m_word_l = 8'h00;
    m_valid = 1'b0; m_overrun = 1'b0; m_perr = 1'b0; m_par_phase = 1'b0;
    m_count = 0;
  endtask

  task automatic model_edge(input logic clr, input logic v, input logic b, input logic rdy);
    logic       pub;
    logic [7:0] pw_m, pw_l;
    logic       pp;
    pub = 1'b0; pw_m = 8'h00; pw_l = 8'h00; pp = 1'b0;
    if (clr) begin
      q.delete();
      m_par_phase = 1'b0;
      m_count = 0;
      m_overrun = 1'b0;
    end else if (v) begin
      if (m_par_phase) begin
        pub = 1'b1; pw_m = pend_m; pw_l = pend_l;
        pp = (^pend_m) ^ b;
        m_par_phase = 1'b0;
        m_count = 9;
      end else begin
        q.push_back(b);
        if (q.size() == 8) begin
          for (int i = 0; i < 8; i++) begin
            pend_m[7-i] = q[i];
            pend_l[i]   = q[i];
          end
          q.delete();
`ifdef SERIAL_COLLECTOR_PARITY_EN
          m_par_phase = 1'b1;
          m_count = 8;
`else
          pub = 1'b1; pw_m = pend_m; pw_l = pend_l;
          m_count = 0;
`endif
        end else begin
          m_count = q.size();
        end
      end
    end else if (m_count == 9) begin
      m_count = 0;
    end

    if (pub && (!m_valid || rdy)) begin
      m_word_m = pw_m; m_word_l = pw_l; m_valid = 1'b1; m_perr = pp;
    end else if (pub) begin
      m_overrun = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle(input logic clr, input logic v, input logic b, input logic rdy);
    clear = clr; in_valid = v; in_bit = b; out_ready = rdy;
    @(posedge clock);
    model_edge(clr, v, b, rdy);
    @(negedge clock);
  endtask

  // One word MSB-first; rdy_last applies to the publishing cycle (last data bit or parity bit).
  task automatic send_word(input logic [7:0] w, input logic rdy_body, input logic rdy_last);
`ifdef SERIAL_COLLECTOR_PARITY_EN
    for (int i = 7; i >= 0; i--) cycle(1'b0, 1'b1, w[i], rdy_body);
    cycle(1'b0, 1'b1, ^w, rdy_last);
`else
    for (int i = 7; i > 0; i--) cycle(1'b0, 1'b1, w[i], rdy_body);
    cycle(1'b0, 1'b1, w[0], rdy_last);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [7:0] a5;
    a5 = 8'hA5;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({if_m.out_word, if_m.out_valid, cnt_m, ovr_m, perr_m} !== 16'h0) begin
      errors++; $display("FAIL reset_state_msb: got %h expected 0", {if_m.out_word, if_m.out_valid, cnt_m, ovr_m, perr_m});
    end
    checks++;
    if ({if_l.out_word, if_l.out_valid, cnt_l, ovr_l, perr_l} !== 16'h0) begin
      errors++; $display("FAIL reset_state_lsb: got %h expected 0", {if_l.out_word, if_l.out_valid, cnt_l, ovr_l, perr_l});
    end
    reset = 1'b0;
    @(negedge clock);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (cnt_m !== 4'd3) begin errors++; $display("FAIL count_3_bits: got %0d expected 3", cnt_m); end
    do_reset();
    checks++;
    if (cnt_m !== 4'd0 || if_m.out_valid !== 1'b0) begin
      errors++; $display("FAIL midword_reset: got cnt=%0d valid=%b expected 0/0", cnt_m, if_m.out_valid);
    end
    for (int i = 7; i > 0; i--) cycle(1'b0, 1'b1, a5[i], 1'b1);
    checks++;
    if (if_m.out_valid !== 1'b0) begin errors++; $display("FAIL a5_early_valid: got %b expected 0", if_m.out_valid); end
`ifdef SERIAL_COLLECTOR_PARITY_EN
    cycle(1'b0, 1'b1, a5[0], 1'b1);
    cycle(1'b0, 1'b1, ^a5, 1'b1);
`else
    cycle(1'b0, 1'b1, a5[0], 1'b1);
`endif
    checks++;
    if (if_m.out_valid !== 1'b1 || if_m.out_word !== 8'hA5 || ovr_m !== 1'b0) begin
      errors++; $display("FAIL a5_publish: got v=%b w=%h ovr=%b expected 1/a5/0", if_m.out_valid, if_m.out_word, ovr_m);
    end
    checks++;
    if (if_l.out_word !== 8'hA5) begin errors++; $display("FAIL a5_lsb_word: got %h expected a5", if_l.out_word); end
  endtask

  task automatic test_lsb_first();
    send_word(8'hC0, 1'b1, 1'b1);
    checks++;
    if (if_l.out_word !== 8'h03 || if_l.out_valid !== 1'b1) begin
      errors++; $display("FAIL lsb_first_word: got %h v=%b expected 03 v=1", if_l.out_word, if_l.out_valid);
    end
    checks++;
    if (if_m.out_word !== 8'hC0) begin errors++; $display("FAIL msb_first_word: got %h expected c0", if_m.out_word); end
  endtask

  task automatic test_overrun();
    send_word(8'h3C, 1'b1, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0);
    checks++;
    if (if_m.out_word !== 8'h3C || if_m.out_valid !== 1'b1 || ovr_m !== 1'b1) begin
      errors++; $display("FAIL overrun_drop: got w=%h v=%b ovr=%b expected 3c/1/1", if_m.out_word, if_m.out_valid, ovr_m);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ovr_m !== 1'b0 || if_m.out_valid !== 1'b1 || if_m.out_word !== 8'h3C) begin
      errors++; $display("FAIL overrun_clear: got ovr=%b v=%b w=%h expected 0/1/3c", ovr_m, if_m.out_valid, if_m.out_word);
    end
  endtask

  task automatic test_accept_publish();
    send_word(8'h0F, 1'b1, 1'b0);
    checks++;
    if (if_m.out_word !== 8'h0F || if_m.out_valid !== 1'b1) begin
      errors++; $display("FAIL hold_0f: got w=%h v=%b expected 0f/1", if_m.out_word, if_m.out_valid);
    end
    send_word(8'hF0, 1'b0, 1'b1);
    checks++;
    if (if_m.out_word !== 8'hF0 || if_m.out_valid !== 1'b1 || ovr_m !== 1'b0) begin
      errors++; $display("FAIL accept_and_publish: got w=%h v=%b ovr=%b expected f0/1/0", if_m.out_word, if_m.out_valid, ovr_m);
    end
  endtask

  task automatic test_clear_mid();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (cnt_m !== 4'd0 || if_m.out_valid !== 1'b1 || if_m.out_word !== 8'hF0) begin
      errors++; $display("FAIL clear_mid_word: got cnt=%0d v=%b w=%h expected 0/1/f0", cnt_m, if_m.out_valid, if_m.out_word);
    end
    send_word(8'h81, 1'b1, 1'b1);
    checks++;
    if (if_m.out_word !== 8'h81 || if_l.out_word !== 8'h81 || if_m.out_valid !== 1'b1) begin
      errors++; $display("FAIL after_clear_81: got m=%h l=%h v=%b expected 81/81/1", if_m.out_word, if_l.out_word, if_m.out_valid);
    end
  endtask

  task automatic test_parity_and_count();
    logic [7:0] w;
    w = 8'h07;
    for (int i = 7; i > 0; i--) cycle(1'b0, 1'b1, w[i], 1'b1);
    checks++;
    if (cnt_m !== 4'd7) begin errors++; $display("FAIL count_7: got %0d expected 7", cnt_m); end
    cycle(1'b0, 1'b1, w[0], 1'b1);
`ifdef SERIAL_COLLECTOR_PARITY_EN
    checks++;
    if (cnt_m !== 4'd8) begin errors++; $display("FAIL count_8_parity_wait: got %0d expected 8", cnt_m); end
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (cnt_m !== 4'd9 || perr_m !== 1'b0 || if_m.out_word !== 8'h07) begin
      errors++; $display("FAIL parity_good: got cnt=%0d perr=%b w=%h expected 9/0/07", cnt_m, perr_m, if_m.out_word);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (cnt_m !== 4'd0) begin errors++; $display("FAIL count_after_peak: got %0d expected 0", cnt_m); end
    for (int i = 7; i >= 0; i--) cycle(1'b0, 1'b1, w[i], 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (perr_m !== 1'b1 || perr_l !== 1'b1) begin
      errors++; $display("FAIL parity_bad: got m=%b l=%b expected 1/1", perr_m, perr_l);
    end
`else
    checks++;
    if (cnt_m !== 4'd0 || perr_m !== 1'b0 || if_m.out_word !== 8'h07) begin
      errors++; $display("FAIL word_end_count: got cnt=%0d perr=%b w=%h expected 0/0/07", cnt_m, perr_m, if_m.out_word);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent[$];
    logic [7:0] got[$];
    logic [7:0] w;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      w = 8'($urandom);
      sent.push_back(w);
      for (int i = 7; i >= 0; i--) begin
        cycle(1'b0, 1'b1, w[i], 1'b1);
        if (if_m.out_valid) got.push_back(if_m.out_word);
      end
`ifdef SERIAL_COLLECTOR_PARITY_EN
      cycle(1'b0, 1'b1, ^w, 1'b1);
      if (if_m.out_valid) got.push_back(if_m.out_word);
`endif
    end
    checks++;
    if (got.size() != sent.size()) begin
      errors++; $display("FAIL b2b_word_count: got %0d expected %0d", got.size(), sent.size());
    end else begin
      for (int k = 0; k < sent.size(); k++) begin
        checks++;
        if (got[k] !== sent[k]) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", k, got[k], sent[k]); end
      end
    end
    checks++;
    if (ovr_m !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", ovr_m); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
      checks++;
      if ({if_m.out_word, if_m.out_valid, ovr_m, cnt_m, perr_m} !== {m_word_m, m_valid, m_overrun, 4'(m_count), m_perr}) begin
        errors++;
        $display("FAIL random_msb cyc%0d: got w=%h v=%b o=%b c=%0d p=%b expected w=%h v=%b o=%b c=%0d p=%b", n,
                 if_m.out_word, if_m.out_valid, ovr_m, cnt_m, perr_m, m_word_m, m_valid, m_overrun, m_count, m_perr);
      end
      checks++;
      if ({if_l.out_word, if_l.out_valid, ovr_l, cnt_l, perr_l} !== {m_word_l, m_valid, m_overrun, 4'(m_count), m_perr}) begin
        errors++;
        $display("FAIL random_lsb cyc%0d: got w=%h v=%b o=%b c=%0d p=%b expected w=%h v=%b o=%b c=%0d p=%b", n,
                 if_l.out_word, if_l.out_valid, ovr_l, cnt_l, perr_l, m_word_l, m_valid, m_overrun, m_count, m_perr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_overrun();
    test_accept_publish();
    test_clear_mid();
    test_parity_and_count();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
